// File: rtl/fifo_write_ctrl.sv
// Write-domain pointer/full controller for a dual-clock FIFO, with built-in read-pointer synchronizer.
// Latency: flags and fill_level update on the same edge as an accepted write; read frees seen after SYNC_STAGES+1 edges.
// Backpressure: write_accept drops while full or clear; dropped writes raise overflow (sticky + count under FIFO_WR_OVERFLOW_STICKY_EN).
module fifo_write_ctrl #(
    parameter int ADDRSIZE     = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 28
) (
    input  logic                write_clk,
    input  logic                write_rst,
    input  logic                clear,
    input  logic                write_enable,
    input  logic [ADDRSIZE:0]   read_ptr_gray,
    output logic                write_accept,
    output logic [ADDRSIZE-1:0] write_addr,
    output logic [ADDRSIZE:0]   write_ptr,
    output logic                full,
    output logic                almost_full,
    output logic [ADDRSIZE:0]   fill_level,
`ifdef FIFO_WR_OVERFLOW_STICKY_EN
    output logic [ADDRSIZE:0]   overflow_count,
`endif
    output logic                overflow
);

    localparam logic [ADDRSIZE:0] AFULL_TH = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] rq_gray;
    logic [ADDRSIZE:0] rq_bin;
    logic [ADDRSIZE:0] write_bin;
    logic [ADDRSIZE:0] write_bin_next;
    logic [ADDRSIZE:0] write_gray_next;
    logic [ADDRSIZE:0] fill_next;
    logic [ADDRSIZE:0] full_match;
    logic              overflow_set;

    // Plain flop chain bringing the read pointer into write_clk; clear deliberately leaves it alone.
    always_ff @(posedge write_clk or negedge write_rst) begin
        if (!write_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= read_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_gray = sync_q[SYNC_STAGES-1];

    // Gray to binary: each bit is the XOR of itself and every more-significant Gray bit.
    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    // Reset gates the strobe so the RAM never sees a write while the pointer is held at zero.
    assign write_accept    = write_enable & ~full & ~clear & write_rst;
    assign overflow_set    = write_enable & full & ~clear;
    assign write_bin_next  = write_bin + {{ADDRSIZE{1'b0}}, write_accept};
    assign write_gray_next = (write_bin_next >> 1) ^ write_bin_next;
    // Modular difference stays correct across pointer wrap.
    assign fill_next       = write_bin_next - rq_bin;
    assign full_match      = {~rq_gray[ADDRSIZE:ADDRSIZE-1], rq_gray[ADDRSIZE-2:0]};
    assign write_addr      = write_bin[ADDRSIZE-1:0];

    // Pointer and status registers advance together so flags carry no extra latency over the write.
    always_ff @(posedge write_clk or negedge write_rst) begin
        if (!write_rst) begin
            write_bin   <= '0;
            write_ptr   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            fill_level  <= '0;
        end else if (clear) begin
            write_bin   <= '0;
            write_ptr   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            fill_level  <= '0;
        end else begin
            write_bin   <= write_bin_next;
            write_ptr   <= write_gray_next;
            full        <= (write_gray_next == full_match);
            almost_full <= (fill_next >= AFULL_TH);
            fill_level  <= fill_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_STICKY_EN
    // Sticky overflow flag plus a saturating count of dropped writes, both flushed by clear.
    always_ff @(posedge write_clk or negedge write_rst) begin
        if (!write_rst) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (clear) begin
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
            if (overflow_count != '1) begin
                overflow_count <= overflow_count + 1'b1;
            end
        end
    end
`else
    // One-cycle overflow pulse for each write dropped because the FIFO was full.
    always_ff @(posedge write_clk or negedge write_rst) begin
        if (!write_rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow_set;
        end
    end
`endif

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
Write-domain controller for the dual-clock FIFO: next generation of the write-pointer/full block. Adds a built-in read-pointer synchronizer of configurable depth, a fill-level count, a programmable almost-full flag, a write-accept strobe and overflow reporting. It sits in write_clk between the producer and the dual-port RAM. It exports a Gray write pointer to the read-domain controller.

Parameters:
ADDRSIZE, 5, address width; depth = 2^ADDRSIZE; legal range ≥ 2
SYNC_STAGES, 2, flop stages synchronizing read_ptr_gray into write_clk; legal range ≥ 2
AFULL_THRESH, 28, almost_full asserts when fill_level ≥ this value; legal range 1..2^ADDRSIZE

Ports:
write_clk  input  1  write-domain clock
write_rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush, write_clk domain
write_enable  input  1  producer write request
read_ptr_gray  input  ADDRSIZE+1  Gray read pointer from the read domain (asynchronous)
write_accept  output  1  combinational: write_enable & ~full & ~clear; RAM write strobe
write_addr  output  ADDRSIZE  binary RAM write address = write_bin[ADDRSIZE-1:0]
write_ptr  output  ADDRSIZE+1  registered Gray write pointer to the read domain
full  output  1  registered full flag
almost_full  output  1  registered almost-full flag
fill_level  output  ADDRSIZE+1  registered occupancy as seen from the write side, 0..2^ADDRSIZE
overflow  output  1  write attempted while full

Behaviour:
- Reset (write_rst low, asynchronous): write_bin, write_ptr, full, almost_full, fill_level, overflow and all synchronizer flops = 0. write_addr = 0 and write_accept = 0.
- Synchronizer: SYNC_STAGES-flop chain on read_ptr_gray produces rq_gray. No logic between stages. Not affected by clear.
- rq_bin is the Gray-to-binary conversion of rq_gray (XOR-prefix from the MSB).
- write_bin_next = write_bin + write_accept, modulo 2^(ADDRSIZE+1).
- write_gray_next = (write_bin_next >> 1) ^ write_bin_next.
- Each write_clk edge, no clear:
  - write_bin ← write_bin_next; write_ptr ← write_gray_next
  - fill_level ← write_bin_next − rq_bin, modulo 2^(ADDRSIZE+1)
  - full ← (write_gray_next == {~rq_gray[ADDRSIZE:ADDRSIZE-1], rq_gray[ADDRSIZE-2:0]})
  - almost_full ← (write_bin_next − rq_bin) ≥ AFULL_THRESH
- Invariant: full == (fill_level == 2^ADDRSIZE) in every cycle.
- Flag latency: flags and fill_level reflect an accepted write on the same edge that advances the pointer, i.e. zero added latency.
- Read-side frees become visible after SYNC_STAGES write_clk edges plus one flag-register edge. The flags are pessimistic and never under-report occupancy.
- Write while full: write_accept = 0, pointer unchanged, overflow = 1 for one cycle on the next edge (default pulse mode).
- Clear: takes priority over write_enable. On the clear edge, write_bin, write_ptr, full, almost_full, fill_level and overflow ← 0. From the following edge, flags are recomputed from rq_bin. The read side must be cleared concurrently; the system guarantees this.
- Clear and write_enable both high: no write is accepted; write_accept = 0.
- Pointer wrap: write_bin wraps from 2^(ADDRSIZE+1)−1 to 0 with no special handling. The modular subtraction keeps fill_level correct.
- No other state machine: the block is a pure pointer/counter datapath with registered status.

Optional Feature:
FIFO_WR_OVERFLOW_STICKY_EN
- Defined: overflow is sticky. It sets on the first dropped write and holds until clear or reset. An additional registered output overflow_count (ADDRSIZE+1 bits) counts dropped writes and saturates at all-ones. It clears on clear or reset.
- Undefined: overflow is a one-cycle pulse per dropped write. overflow_count does not exist.

Test Plan:
1. Reset: hold write_rst=0 with write_enable=1 → all outputs 0, write_addr=0. Release → first write_enable=1 gives write_addr 0→1, write_ptr=6'b000001.
2. Fill to full: read_ptr_gray=0, 32 consecutive writes:
   - fill_level steps 1..32
   - almost_full rises at the 28th accepted write's edge
   - full rises at the 32nd, write_ptr=6'b110000
   - 33rd write → write_accept=0, pointer unchanged, overflow pulses for 1 cycle
3. Drain visibility: from full, drive read_ptr_gray=6'b000001 → full falls and fill_level=31 exactly 3 edges later (SYNC_STAGES=2).
4. Clear while full with write_enable=1 → next edge: write_ptr=0, fill_level=0, full=0, almost_full=0. write_accept=0 during the clear cycle.
5. Wrap: 100 writes with read_ptr_gray tracking, lag ≤ 4 → write_bin wraps 63→0 (write_ptr 6'b100000→6'b000000). fill_level stays ≤ 4 and matches the reference model each cycle. No spurious full.
6. With FIFO_WR_OVERFLOW_STICKY_EN: fill, then 3 writes while full → overflow stays 1, overflow_count=3. Clear → both return to 0.
